// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: word-addressed backing store behind independent read/write FSMs.
// Define AXI_MEM_RESPONDER_RANGE_CHECK_EN to reject out-of-range beats instead of wrapping.

package ariane_axi;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;
endpackage

module axi_mem_responder #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned MemWords     = 256,
  parameter type         axi_req_t    = ariane_axi::req_t,
  parameter type         axi_rsp_t    = ariane_axi::resp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_resp_o,
  output logic     busy_o
);
  localparam int unsigned StrbW = AxiDataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MemWords);
  typedef logic [AxiAddrWidth-1:0] idx_t;

  typedef enum logic       {R_IDLE, R_BURST}         r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;

  logic [AxiDataWidth-1:0] mem [MemWords];

  logic [AxiIdWidth-1:0]   r_id_q, w_id_q;
  idx_t                    r_idx_q, w_idx_q;
  logic [7:0]              r_len_q, r_beat_q, w_len_q, w_beat_q;
  logic [AxiDataWidth-1:0] r_data_q, fetch_data;
  logic                    r_err_q, w_err_q, w_over_q;

  logic ar_ready, aw_ready, w_ready, r_valid, b_valid;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs, r_last, w_at_len;
  logic fetch_ok, w_ok, mem_we;
  idx_t ar_idx, aw_idx, fetch_idx, w_cur;

  assign ar_ready = !rst_i && (r_state_q == R_IDLE);
  assign aw_ready = !rst_i && (w_state_q == W_IDLE);
  assign w_ready  = (w_state_q == W_DATA);
  assign r_valid  = (r_state_q == R_BURST);
  assign b_valid  = (w_state_q == W_RESP);

  assign ar_hs = axi_req_i.ar_valid && ar_ready;
  assign aw_hs = axi_req_i.aw_valid && aw_ready;
  assign w_hs  = axi_req_i.w_valid  && w_ready;
  assign r_hs  = axi_req_i.r_ready  && r_valid;
  assign b_hs  = axi_req_i.b_ready  && b_valid;

  assign ar_idx   = idx_t'(axi_req_i.ar.addr) >> OffW;
  assign aw_idx   = idx_t'(axi_req_i.aw.addr) >> OffW;
  assign r_last   = (r_beat_q == r_len_q);
  assign w_at_len = (w_beat_q == w_len_q);
  assign w_cur    = w_idx_q + idx_t'(w_beat_q);

  // Data is fetched into a register at the AR handshake and at each R handshake,
  // so R holds stable under back-pressure and a same-edge write is not observed.
  assign fetch_idx = (r_state_q == R_IDLE) ? ar_idx : r_idx_q + idx_t'(r_beat_q) + idx_t'(1);

`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
  assign fetch_ok = fetch_idx < idx_t'(MemWords);
  assign w_ok     = w_cur < idx_t'(MemWords);
`else
  assign fetch_ok = 1'b1;
  assign w_ok     = 1'b1;
`endif

  assign fetch_data = fetch_ok ? mem[fetch_idx[IdxW-1:0]] : '0;
  assign mem_we     = w_hs && !w_over_q && w_ok;

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_BURST;
      R_BURST: if (r_hs && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && axi_req_i.w.last) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_data_q  <= '0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q   <= AxiIdWidth'(axi_req_i.ar.id);
        r_idx_q  <= ar_idx;
        r_len_q  <= axi_req_i.ar.len;
        r_beat_q <= '0;
        r_data_q <= fetch_data;
        r_err_q  <= !fetch_ok;
      end else if (r_hs && !r_last) begin
        r_beat_q <= r_beat_q + 8'd1;
        r_data_q <= fetch_data;
        r_err_q  <= !fetch_ok;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      w_over_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_id_q   <= AxiIdWidth'(axi_req_i.aw.id);
        w_idx_q  <= aw_idx;
        w_len_q  <= axi_req_i.aw.len;
        w_beat_q <= '0;
        w_err_q  <= 1'b0;
        w_over_q <= 1'b0;
      end else if (w_hs) begin
        if ((axi_req_i.w.last != w_at_len) || (!w_ok && !w_over_q)) w_err_q <= 1'b1;
        // Past the final beat without w_last: swallow beats until w_last arrives.
        if (!w_at_len)                            w_beat_q <= w_beat_q + 8'd1;
        else if (!axi_req_i.w.last)               w_over_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (axi_req_i.w.strb[b]) mem[w_cur[IdxW-1:0]][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.r_valid  = r_valid;
    axi_resp_o.r.id     = r_id_q;
    axi_resp_o.r.data   = r_data_q;
    axi_resp_o.r.resp   = r_err_q ? 2'b10 : 2'b00;
    axi_resp_o.r.last   = r_last;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.b.id     = w_id_q;
    axi_resp_o.b.resp   = w_err_q ? 2'b10 : 2'b00;
  end

  assign busy_o = (r_state_q != R_IDLE) || (w_state_q != W_IDLE);

  logic unused;
  assign unused = ^{axi_req_i, fetch_idx, w_cur, ar_idx, aw_idx};
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed + randomized bench for axi_mem_responder against an array-based memory model.
module tb_axi_mem_responder;
  localparam int MW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ariane_axi::req_t  req;
  ariane_axi::resp_t rsp;
  logic busy;

  logic [63:0] model [MW];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .axi_req_i  (req),
    .axi_resp_o (rsp),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit idx_ok(input longint unsigned i);
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
    return i < MW;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] exp_data(input longint unsigned i);
    return idx_ok(i) ? model[i % MW] : 64'h0;
  endfunction

  // nbeats != len+1 models a mismatched w_last; only beats 0..len may land in memory.
  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input int len,
                          input int nbeats, input bit seq, input bit rnd_strb);
    longint unsigned base = addr >> 3;
    bit err = (nbeats != len + 1);
    int t = 0;
    logic [63:0] d;
    logic [7:0] s;
    req.aw = '0; req.aw.id = id; req.aw.addr = addr; req.aw.len = 8'(len);
    req.aw_valid = 1'b1;
    while (!rsp.aw_ready && t < 20) begin tick(); t++; end
    chk("aw_ready", rsp.aw_ready, 1);
    tick();
    req.aw_valid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      d = seq ? 64'(k + 1) : {$urandom, $urandom};
      s = rnd_strb ? 8'($urandom) : 8'hff;
      req.w = '0; req.w.data = d; req.w.strb = s; req.w.last = (k == nbeats - 1);
      req.w_valid = 1'b1;
      t = 0;
      while (!rsp.w_ready && t < 20) begin tick(); t++; end
      chk("w_ready", rsp.w_ready, 1);
      if (k == nbeats - 1) chk("b_valid_on_last_w", rsp.b_valid, 0);
      tick();
      if (k <= len) begin
        if (idx_ok(base + k)) begin
          for (int b = 0; b < 8; b++)
            if (s[b]) model[(base + k) % MW][8*b +: 8] = d[8*b +: 8];
        end else err = 1'b1;
      end
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    chk("b_valid", rsp.b_valid, 1);
    chk("b_id", rsp.b.id, id);
    chk("b_resp", rsp.b.resp, err ? 2'b10 : 2'b00);
    req.b_ready = 1'b1;
    tick();
    req.b_ready = 1'b0;
    chk("b_valid_after", rsp.b_valid, 0);
    chk("aw_ready_after", rsp.aw_ready, 1);
  endtask

  // stall < 0 picks a random 0..2 cycle stall per beat.
  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input int len, input int stall);
    longint unsigned base = addr >> 3;
    int t = 0;
    int st;
    req.ar = '0; req.ar.id = id; req.ar.addr = addr; req.ar.len = 8'(len);
    req.ar_valid = 1'b1;
    while (!rsp.ar_ready && t < 20) begin tick(); t++; end
    chk("ar_ready", rsp.ar_ready, 1);
    tick();
    req.ar_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int c = 0; c <= st; c++) begin
        chk("r_valid", rsp.r_valid, 1);
        chk("r_data", rsp.r.data, exp_data(base + k));
        chk("r_id", rsp.r.id, id);
        chk("r_last", rsp.r.last, k == len);
        chk("r_resp", rsp.r.resp, idx_ok(base + k) ? 2'b00 : 2'b10);
        chk("ar_ready_busy", rsp.ar_ready, 0);
        req.r_ready = (c == st);
        tick();
      end
    end
    req.r_ready = 1'b0;
    chk("r_valid_done", rsp.r_valid, 0);
    chk("ar_ready_done", rsp.ar_ready, 1);
  endtask

  initial begin
    logic [63:0] a_old, b_new;
    int len;
    longint unsigned idx;
    req = '0;
    #2 rst = 1'b1;
    tick(); tick();
    chk("rst_ar_ready", rsp.ar_ready, 0);
    chk("rst_aw_ready", rsp.aw_ready, 0);
    chk("rst_w_ready", rsp.w_ready, 0);
    chk("rst_r_valid", rsp.r_valid, 0);
    chk("rst_b_valid", rsp.b_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ar_ready", rsp.ar_ready, 1);
    chk("post_rst_aw_ready", rsp.aw_ready, 1);

    // 4-beat burst, data 1..4, then read it back
    do_write(4'b1100, 64'h40, 3, 4, 1'b1, 1'b0);
    do_read(4'b1100, 64'h40, 3, 0);

    // back-pressure: r_ready low for 3 cycles on each beat
    do_write(4'h2, 64'h100, 1, 2, 1'b0, 1'b0);
    do_read(4'b1001, 64'h100, 1, 3);

    // early w_last -> SLVERR, then a clean burst -> OKAY
    do_write(4'h3, 64'h200, 2, 2, 1'b0, 1'b0);
    do_write(4'h3, 64'h200, 2, 3, 1'b0, 1'b0);
    do_read(4'h3, 64'h200, 2, -1);

    // missing w_last: extra beats swallowed, only beat 0 lands
    do_write(4'h4, 64'h300, 0, 3, 1'b0, 1'b0);
    do_read(4'h4, 64'h300, 1, 0);

    // burst crossing the top of memory, then a read one past the end
    do_write(4'h5, 64'(254 * 8), 3, 4, 1'b0, 1'b0);
    do_read(4'h5, 64'(254 * 8), 3, 0);
    do_read(4'h6, 64'(MW * 8), 0, 0);

    // reset during beat 2 of a len=7 read
    do_write(4'h7, 64'h400, 7, 8, 1'b0, 1'b1);
    req.ar = '0; req.ar.id = 4'h7; req.ar.addr = 64'h400; req.ar.len = 8'd7;
    req.ar_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0;
    req.r_ready = 1'b1;
    tick(); tick();
    chk("mid_burst_r_valid", rsp.r_valid, 1);
    chk("mid_burst_r_data", rsp.r.data, model[(64'h400 >> 3) + 2]);
    req.r_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_r_valid", rsp.r_valid, 0);
    chk("abort_ar_ready", rsp.ar_ready, 0);
    chk("abort_busy", busy, 0);
    tick(); tick();
    chk("abort_hold_r_valid", rsp.r_valid, 0);
    rst = 1'b0;
    #1;
    chk("rerelease_ar_ready", rsp.ar_ready, 1);
    chk("rerelease_r_valid", rsp.r_valid, 0);
    do_read(4'h7, 64'h400, 7, -1);
    do_read(4'b1100, 64'h40, 3, 0);

    // same-cycle read and write of word 5
    do_write(4'h8, 64'h28, 0, 1, 1'b0, 1'b0);
    a_old = model[5];
    b_new = ~a_old;
    req.aw = '0; req.aw.id = 4'h9; req.aw.addr = 64'h28; req.aw.len = 8'd0;
    req.aw_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0;
    req.w = '0; req.w.data = b_new; req.w.strb = 8'hff; req.w.last = 1'b1; req.w_valid = 1'b1;
    req.ar = '0; req.ar.id = 4'ha; req.ar.addr = 64'h28; req.ar.len = 8'd0; req.ar_valid = 1'b1;
    chk("coll_ar_ready", rsp.ar_ready, 1);
    chk("coll_w_ready", rsp.w_ready, 1);
    tick();
    req.w_valid = 1'b0; req.ar_valid = 1'b0;
    model[5] = b_new;
    chk("coll_r_valid", rsp.r_valid, 1);
    chk("coll_r_data_old", rsp.r.data, a_old);
    chk("coll_b_valid", rsp.b_valid, 1);
    chk("coll_b_resp", rsp.b.resp, 2'b00);
    req.r_ready = 1'b1; req.b_ready = 1'b1;
    tick();
    req.r_ready = 1'b0; req.b_ready = 1'b0;
    chk("coll_busy", busy, 0);
    do_read(4'hb, 64'h28, 0, 0);

    // randomized bursts inside the array
    for (int i = 0; i < 10; i++) begin
      len = int'($urandom_range(0, 7));
      idx = longint'($urandom_range(0, MW - 1 - len));
      do_write(4'($urandom), 64'(idx * 8 + $urandom_range(0, 7)), len, len + 1, 1'b0, 1'b1);
      do_read(4'($urandom), 64'(idx * 8), len, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 64, AXI address width.
REQ-002 SHALL have parameter AxiDataWidth, default 64, AXI data width; every beat is full-width.
REQ-003 SHALL have parameter AxiIdWidth, default 4, AXI ID width.
REQ-004 SHALL have parameter MemWords, default 256, backing-store depth in AxiDataWidth words; power of two.
REQ-005 SHALL have type parameters axi_req_t and axi_rsp_t, defaulting to ariane_axi::req_t and ariane_axi::resp_t.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port axi_req_i, input, axi_req_t, AR/AW/W channels plus r_ready and b_ready from the initiator.
REQ-009 SHALL have port axi_resp_o, output, axi_rsp_t, ar_ready, aw_ready, w_ready, and the R and B channels.
REQ-010 SHALL have port busy_o, output, 1, high while either FSM is not idle.

Function
REQ-011 SHALL implement the AXI4 responder end of the cache-subsystem master port, with independent read and write FSMs.
REQ-012 SHALL map word index = addr >> log2(AxiDataWidth/8); beat k of a burst uses index + k (INCR only); burst type and size are ignored.
REQ-013 Read FSM states SHALL be R_IDLE and R_BURST.
REQ-014 R_IDLE: ar_ready=1; on ar_valid&ar_ready, latch id, addr and len, reset the beat counter to 0, go to R_BURST.
REQ-015 R_BURST: r_valid=1, r_id=latched id, r_data=mem[index+beat], r_last=(beat==len), ar_ready=0.
REQ-016 On r_valid&r_ready in R_BURST, the beat counter SHALL increment; if r_last, the FSM SHALL return to R_IDLE; if r_ready=0, all R outputs SHALL hold stable.
REQ-017 Read latency SHALL be: AR handshake in cycle N, first r_valid in cycle N+1; the next AR is accepted no earlier than the cycle after the last R handshake.
REQ-018 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP.
REQ-019 W_IDLE: aw_ready=1, w_ready=0; on the AW handshake, latch id, addr and len, clear the beat counter, clear the error flag, go to W_DATA.
REQ-020 W_DATA: w_ready=1; each W handshake writes the strobed bytes (w_strb) of mem[index+beat] at the clock edge; on the handshake with w_last=1, go to W_RESP.
REQ-021 If w_last=1 with beat!=len, or beat==len with w_last=0, the error flag SHALL be set.
REQ-022 On beat==len with w_last=0, further beats SHALL be accepted but not written until w_last.
REQ-023 W_RESP: b_valid=1, b_id=latched id, b_resp=2'b10 if the error flag is set, else 2'b00; on b_ready, return to W_IDLE.
REQ-024 On the cycle of the last W handshake, b_valid SHALL be 0; it SHALL be 1 from the next cycle.
REQ-025 Same-cycle read and write to the same word: the read SHALL return the old value; the write commits at the edge.
REQ-026 r_resp SHALL be 2'b00 unless REQ-034 applies.
REQ-027 Unused response fields (user, ACE snoop signals) SHALL be driven 0.

Reset
REQ-028 While rst_i=1, both FSMs SHALL be idle and ar_ready, aw_ready, w_ready, r_valid, b_valid and busy_o SHALL be 0.
REQ-029 From the first cycle after rst_i deasserts, ar_ready=1 and aw_ready=1.
REQ-030 Reset mid-burst SHALL abort the burst with no further R or B beats; memory contents are not reset and are retained.

Configuration
REQ-031 The macro AXI_MEM_RESPONDER_RANGE_CHECK_EN SHALL compile in address range checking.
REQ-032 With the macro defined: a beat whose index is >= MemWords SHALL not be written, and the write SHALL set the error flag.
REQ-033 Without the macro: the index SHALL be taken modulo MemWords (wrap-around), and all responses SHALL be OKAY except the REQ-021 length error.
REQ-034 With the macro defined: a read beat whose index is >= MemWords SHALL return r_data=0 with r_resp=2'b10.

Verification
REQ-035 Write AW id=4'b1100, addr 0x40, len=3, data 1..4, strb all ones, then read the same burst -> B id=1100 OKAY, one cycle after the last W; R returns 1,2,3,4, r_last on beat 3, id=1100.
REQ-036 Read id=4'b1001, len=1, with r_ready held low 3 cycles -> r_data/r_id/r_last stable; ar_ready=0 until after the final R handshake.
REQ-037 Write len=2 with w_last on beat 1 -> B resp 2'b10; a subsequent write of the same len with a correct w_last -> OKAY.
REQ-038 With the macro defined: read at index MemWords, len=0 -> r_data=0, r_resp=2'b10; without it -> returns mem[0].
REQ-039 Assert rst_i during beat 2 of a len=7 read -> r_valid=0 immediately; after release ar_ready=1; earlier-written data is still readable.
REQ-040 Simultaneous read and write of word 5 (old value A, new value B) -> R returns A; a later read returns B.
